// File: rtl/pillar_pkg.sv
// pillar_pkg: shared types and constants for the Pillar fetch stage
//   fetch_state_e        - fetch FSM states (IDLE/REQ/VALID)
//   XLEN                 - datapath width
//   INSTR_BYTES          - bytes per instruction word (PC increment)
//   RESET_VECTOR_DEFAULT - default PC after reset
package pillar_pkg;
   localparam int unsigned XLEN = 32;
   localparam int unsigned INSTR_BYTES = 4;
   localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_VALID = 2'd2
   } fetch_state_e;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: word-read bus between the fetch stage and RAM
//   mem_req  - read request, held until ack or timeout (fetch -> RAM)
//   mem_addr - read address, stable while mem_req=1   (fetch -> RAM)
//   mem_data - read data, valid with mem_ack           (RAM -> fetch)
//   mem_ack  - read complete                           (RAM -> fetch)
interface fetch_unit_if import pillar_pkg::*; ();
   logic            mem_req;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_data;
   logic            mem_ack;
   modport master (output mem_req, mem_addr, input mem_data, mem_ack);
   modport slave (input mem_req, mem_addr, output mem_data, mem_ack);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage - PC register, RAM word read, instruction register
//   clk, reset     - clock and asynchronous active-high reset
//   mem            - RAM read bus (master side)
//   pc_readin_i    - fetch request from control, honoured only in IDLE
//   pc_load_i      - PC redirect strobe, pc_target_i is its word-aligned target
//   instr_o        - fetched instruction, instr_pc_o its address, instr_valid_o its qualifier
//   instr_taken_i  - decode has consumed the instruction
//   pc_o           - next-fetch PC
//   fetch_err_o    - one-cycle pulse when RAM fails to ack within WAIT_LIMIT cycles
module fetch_unit import pillar_pkg::*; #(
   parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
   parameter int unsigned     WAIT_LIMIT   = 16
) (
   input  logic             clk,
   input  logic             reset,
   fetch_unit_if.master     mem,
   input  logic             pc_readin_i,
   input  logic             pc_load_i,
   input  logic [XLEN-1:0]  pc_target_i,
   output logic [XLEN-1:0]  instr_o,
   output logic [XLEN-1:0]  instr_pc_o,
   output logic             instr_valid_o,
   input  logic             instr_taken_i,
   output logic [XLEN-1:0]  pc_o,
   output logic             fetch_err_o
);
   localparam int unsigned CW = $clog2(WAIT_LIMIT + 1);
   // the last waiting cycle; timing out here gives the error exactly WAIT_LIMIT cycles after the request rose
   localparam logic [CW-1:0] LAST_WAIT = CW'(WAIT_LIMIT - 1);
   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, addr_q, addr_d, instr_q, instr_d, ipc_q, ipc_d;
   logic            req_q, req_d, valid_q, valid_d, err_q, err_d, flush_q, flush_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] target;
   assign target = pc_target_i & ~XLEN'(3);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_VECTOR;
         addr_q  <= '0;
         instr_q <= '0;
         ipc_q   <= '0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         flush_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         req_q   <= req_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         flush_q <= flush_d;
         cnt_q   <= cnt_d;
      end
   end
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      req_d   = req_q;
      valid_d = valid_q;
      err_d   = 1'b0;
      flush_d = flush_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            pc_d = pc_load_i ? target : pc_q;
            // a same-cycle redirect supplies the fetch address
            if (pc_readin_i) begin
               state_d = ST_REQ;
               req_d   = 1'b1;
               addr_d  = pc_d;
               cnt_d   = '0;
               flush_d = 1'b0;
            end
         end
         ST_REQ: begin
            // redirects update pc at once; the in-flight address is never changed
            if (pc_load_i) pc_d = target;
            if (mem.mem_ack) begin
               req_d   = 1'b0;
               flush_d = 1'b0;
               if (flush_q || pc_load_i) begin
                  state_d = ST_IDLE;
               end else begin
                  instr_d = mem.mem_data;
                  ipc_d   = addr_q;
                  valid_d = 1'b1;
                  pc_d    = addr_q + XLEN'(INSTR_BYTES);
                  state_d = ST_VALID;
               end
            end else if (cnt_q == LAST_WAIT) begin
               req_d   = 1'b0;
               err_d   = 1'b1;
               flush_d = 1'b0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (pc_load_i) flush_d = 1'b1;
            end
         end
         ST_VALID: begin
            // a redirect drops the held instruction, even if decode takes it this cycle
            if (pc_load_i || instr_taken_i) begin
               valid_d = 1'b0;
               pc_d    = pc_load_i ? target : pc_q;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end
   assign mem.mem_req   = req_q;
   assign mem.mem_addr  = addr_q;
   assign instr_o       = instr_q;
   assign instr_pc_o    = ipc_q;
   assign instr_valid_o = valid_q;
   assign pc_o          = pc_q;
   assign fetch_err_o   = err_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        reset;
   logic        pc_readin, pc_load, taken;
   logic [31:0] target, instr, ipc, pc;
   logic        valid, err;
   int          checks = 0;
   int          errors = 0;
   typedef struct {
      logic [31:0] instr;
      logic [31:0] ipc;
      logic [31:0] pc;
   } exp_t;
   exp_t        exp_q[$];
   logic [31:0] err_q[$];
   logic        prev_valid = 1'b0;
   always #5 clk = ~clk;
   fetch_unit_if bus ();
   fetch_unit #(.RESET_VECTOR(32'h0), .WAIT_LIMIT(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .mem           (bus.master),
      .pc_readin_i   (pc_readin),
      .pc_load_i     (pc_load),
      .pc_target_i   (target),
      .instr_o       (instr),
      .instr_pc_o    (ipc),
      .instr_valid_o (valid),
      .instr_taken_i (taken),
      .pc_o          (pc),
      .fetch_err_o   (err)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   always @(negedge clk) begin
      exp_t e;
      logic [31:0] ep;
      if (!reset && valid && !prev_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got instr %h pc %h expected no instruction", instr, ipc);
         end else begin
            e = exp_q.pop_front();
            chk("instr", instr, e.instr);
            chk("instr_pc", ipc, e.ipc);
            chk("pc_after_fetch", pc, e.pc);
         end
      end
      if (!reset && err) begin
         if (err_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_fetch_err: got 1 expected 0 at %0t", $time);
         end else begin
            ep = err_q.pop_front();
            chk("pc_after_timeout", pc, ep);
         end
      end
      prev_valid = valid;
   end
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end");
      $fatal(1, "watchdog");
   end
   initial begin
      reset = 1'b1;
      pc_readin = 1'b0;
      pc_load = 1'b0;
      taken = 1'b0;
      target = '0;
      bus.mem_ack = 1'b0;
      bus.mem_data = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_pc", pc, 32'h0);
      chk("rst_req", 32'(bus.mem_req), 32'h0);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      reset = 1'b0;
      // basic fetch, ack after 2 cycles
      @(negedge clk);
      pc_readin = 1'b1;
      exp_q.push_back('{32'h13, 32'h0, 32'h4});
      @(negedge clk);
      pc_readin = 1'b0;
      chk("req_latency", 32'(bus.mem_req), 32'h1);
      chk("addr0", bus.mem_addr, 32'h0);
      @(negedge clk);
      @(negedge clk);
      bus.mem_ack = 1'b1;
      bus.mem_data = 32'h0000_0013;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      chk("req_drop_on_ack", 32'(bus.mem_req), 32'h0);
      // hold without taken; readin ignored in VALID
      for (int i = 0; i < 5; i++) begin
         pc_readin = (i == 1);
         @(negedge clk);
         chk("hold_valid", 32'(valid), 32'h1);
         chk("hold_instr", instr, 32'h13);
         chk("hold_ipc", ipc, 32'h0);
         chk("hold_req", 32'(bus.mem_req), 32'h0);
      end
      pc_readin = 1'b0;
      taken = 1'b1;
      @(negedge clk);
      taken = 1'b0;
      chk("taken_clears_valid", 32'(valid), 32'h0);
      @(negedge clk);
      chk("no_queued_req", 32'(bus.mem_req), 32'h0);
      // redirect during REQ, data discarded
      pc_readin = 1'b1;
      @(negedge clk);
      pc_readin = 1'b0;
      chk("addr4", bus.mem_addr, 32'h4);
      pc_load = 1'b1;
      target = 32'h103;
      @(negedge clk);
      pc_load = 1'b0;
      chk("redirect_pc", pc, 32'h100);
      chk("addr_stable", bus.mem_addr, 32'h4);
      chk("req_held", 32'(bus.mem_req), 32'h1);
      @(negedge clk);
      @(negedge clk);
      bus.mem_ack = 1'b1;
      bus.mem_data = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      chk("flush_no_valid", 32'(valid), 32'h0);
      chk("flush_req", 32'(bus.mem_req), 32'h0);
      chk("flush_pc", pc, 32'h100);
      pc_readin = 1'b1;
      exp_q.push_back('{32'h11, 32'h100, 32'h104});
      @(negedge clk);
      pc_readin = 1'b0;
      chk("addr_after_redirect", bus.mem_addr, 32'h100);
      bus.mem_ack = 1'b1;
      bus.mem_data = 32'h11;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      taken = 1'b1;
      @(negedge clk);
      taken = 1'b0;
      // timeout: error exactly 16 cycles after request rise
      pc_readin = 1'b1;
      err_q.push_back(32'h104);
      @(negedge clk);
      pc_readin = 1'b0;
      chk("to_req", 32'(bus.mem_req), 32'h1);
      for (int i = 1; i < 16; i++) begin
         @(negedge clk);
         chk("to_no_err_early", 32'(err), 32'h0);
      end
      @(negedge clk);
      chk("to_err", 32'(err), 32'h1);
      chk("to_req_drop", 32'(bus.mem_req), 32'h0);
      chk("to_pc", pc, 32'h104);
      @(negedge clk);
      chk("to_err_pulse", 32'(err), 32'h0);
      // redirect-then-fetch to top of memory, PC wraps
      pc_load = 1'b1;
      pc_readin = 1'b1;
      target = 32'hFFFF_FFFC;
      exp_q.push_back('{32'hABC, 32'hFFFF_FFFC, 32'h0});
      @(negedge clk);
      pc_load = 1'b0;
      pc_readin = 1'b0;
      chk("wrap_addr", bus.mem_addr, 32'hFFFF_FFFC);
      bus.mem_ack = 1'b1;
      bus.mem_data = 32'hABC;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      // redirect beats taken in VALID
      pc_load = 1'b1;
      taken = 1'b1;
      target = 32'h200;
      @(negedge clk);
      pc_load = 1'b0;
      taken = 1'b0;
      chk("load_over_taken_valid", 32'(valid), 32'h0);
      chk("load_over_taken_pc", pc, 32'h200);
      // async reset mid-REQ
      pc_readin = 1'b1;
      @(negedge clk);
      pc_readin = 1'b0;
      chk("pre_rst_req", 32'(bus.mem_req), 32'h1);
      #2 reset = 1'b1;
      #1;
      chk("arst_req", 32'(bus.mem_req), 32'h0);
      chk("arst_addr", bus.mem_addr, 32'h0);
      chk("arst_pc", pc, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      // async reset mid-VALID
      pc_readin = 1'b1;
      exp_q.push_back('{32'h55, 32'h0, 32'h4});
      @(negedge clk);
      pc_readin = 1'b0;
      bus.mem_ack = 1'b1;
      bus.mem_data = 32'h55;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("arst_valid", 32'(valid), 32'h0);
      chk("arst_instr", instr, 32'h0);
      chk("arst_ipc", ipc, 32'h0);
      chk("arst_pc2", pc, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("post_rst_no_err", 32'(err), 32'h0);
      end
      chk("exp_queue_drained", 32'(exp_q.size()), 32'h0);
      chk("err_queue_drained", 32'(err_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
